// File: rtl/des_perm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_perm_pkg
// Description : Shared definitions for the DES bit-permutation engine.
//               - DES P, IP and FP tables, using DES 1-based MSB-first numbering
//               - permutation direction type
//               - a reference 32-bit DES-P permutation helper
//               - a bijection check that runs when a table is elaborated
// Revision    : 1.0 - initial release
// ============================================================================
package des_perm_pkg;

  // Largest table the elaboration-time check can handle. Each entry is
  // packed into 8 bits for that check.
  localparam int PERM_MAX_W    = 255;
  localparam int PERM_TBL_BITS = PERM_MAX_W * 8;

  typedef enum logic {
    PERM_FWD = 1'b0,
    PERM_INV = 1'b1
  } perm_dir_e;

  localparam int DES_P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int DES_IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int DES_FP_TABLE [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  // Reference DES P permutation on a 32-bit word. Bit n (1-based, from the
  // MSB) lives at vector index 32-n.
  function automatic logic [31:0] perm_apply(input logic [31:0] data,
                                             input perm_dir_e   dir);
    logic [31:0] r;
    r = '0;
    for (int k = 1; k <= 32; k++) begin
      if (dir == PERM_FWD)
        r[32 - k] = data[32 - DES_P_TABLE[k - 1]];
      else
        r[32 - DES_P_TABLE[k - 1]] = data[32 - k];
    end
    return r;
  endfunction

  // The table arrives packed, with 8 bits per entry and entry 0 in the LSBs.
  // The function returns 1 only when the first w entries are each in 1..w
  // and no value appears twice.
  function automatic bit table_is_bijection(input logic [PERM_TBL_BITS-1:0] tbl,
                                            input int                       w);
    bit ok;
    int ek;
    int ej;
    ok = (w >= 1) && (w <= PERM_MAX_W);
    if (ok) begin
      for (int k = 0; k < w; k++) begin
        ek = int'(8'(tbl >> (k * 8)));
        if (ek < 1 || ek > w) ok = 1'b0;
        for (int j = 0; j < k; j++) begin
          ej = int'(8'(tbl >> (j * 8)));
          if (ej == ek) ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_perm_slice.sv
`default_nettype none
// ============================================================================
// Module      : des_perm_slice
// Description : One pipeline register slice, holding a {valid, data} pair.
//               The slice loads whenever it is empty or is emptying in this
//               cycle, so bubbles collapse. The data register holds while the
//               slice is stalled.
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               i_valid    - upstream beat valid
//               i_data     - upstream beat data
//               i_dn_ready - downstream takes this slice's beat this cycle
//               o_up_ready - slice loads from upstream this cycle
//               o_valid    - slice holds a beat
//               o_data     - held beat data
// Revision    : 1.0 - initial release
// ============================================================================
module des_perm_slice #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_dn_ready,
  output logic         o_up_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign w_load     = ~r_valid | i_dn_ready;
  assign o_up_ready = w_load;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      // Data is only captured with a real beat. A bubble leaves the last
      // value in place, so the output does not toggle needlessly.
      if (i_valid) r_data <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/des_perm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : des_perm_pipe
// Description : Pipelined bit-permutation engine for the DES datapath. Each
//               accepted beat is permuted by the compile-time TABLE, then
//               carried through STAGES valid/ready register slices.
//               Optional macro DES_PERM_INV_EN: when defined, in_inv selects
//               the inverse map for each beat. When undefined, in_inv is
//               ignored and only the forward map is built.
// Ports       : clk       - clock, rising edge
//               rst_n     - synchronous active-low reset
//               in_valid  - input beat valid
//               in_ready  - engine accepts the beat this cycle
//               in_data   - input word (W bits)
//               in_inv    - 1 = inverse permutation (DES_PERM_INV_EN only)
//               out_valid - output beat valid
//               out_ready - downstream accepts the beat
//               out_data  - permuted word (W bits)
//               occupancy - number of beats currently held in the pipeline
// Revision    : 1.0 - initial release
// ============================================================================
module des_perm_pipe
  import des_perm_pkg::*;
#(
  parameter int W            = 32,
  parameter int STAGES       = 2,
  parameter int TABLE [W]    = DES_P_TABLE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  in_data,
  input  logic                          in_inv,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W-1:0]                  out_data,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int c_occ_w = $clog2(STAGES + 1);

  // Packs TABLE into the fixed-width form that the package check expects.
  // Out-of-range entries are left as 0, which the check rejects.
  function automatic logic [PERM_TBL_BITS-1:0] pack_table();
    logic [PERM_TBL_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < W && k < PERM_MAX_W; k++) begin
      if (TABLE[k] >= 1 && TABLE[k] <= PERM_MAX_W)
        r = r | (PERM_TBL_BITS'(TABLE[k]) << (k * 8));
    end
    return r;
  endfunction

  localparam bit c_table_ok = table_is_bijection(pack_table(), W);

  // --------------------------------------------------------------------------
  // Elaboration checks
  // --------------------------------------------------------------------------
  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "des_perm_pipe: STAGES must be >= 1");
  end

  // --------------------------------------------------------------------------
  // Combinational permutation ahead of slice 0
  // --------------------------------------------------------------------------
  logic [W-1:0] w_fwd;
  logic [W-1:0] w_perm;
`ifdef DES_PERM_INV_EN
  logic [W-1:0] w_inv;
`endif

  if (!c_table_ok || W < 2) begin : g_bad_table
    $fatal(1, "des_perm_pipe: TABLE is not a bijection on 1..W (or W < 2)");
    assign w_fwd = in_data;
`ifdef DES_PERM_INV_EN
    assign w_inv = in_data;
`endif
  end else begin : g_map
    // DES numbers bits from 1 at the MSB, so entry k maps to index W-k.
    for (genvar k = 1; k <= W; k++) begin : g_bit
      localparam int c_src = W - TABLE[k-1];
      assign w_fwd[W-k] = in_data[c_src];
`ifdef DES_PERM_INV_EN
      assign w_inv[c_src] = in_data[W-k];
`endif
    end
  end

`ifdef DES_PERM_INV_EN
  perm_dir_e w_dir;
  assign w_dir  = in_inv ? PERM_INV : PERM_FWD;
  assign w_perm = (w_dir == PERM_INV) ? w_inv : w_fwd;
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
  assign w_perm       = w_fwd;
`endif

  // --------------------------------------------------------------------------
  // Register slices. Ready ripples backwards from out_ready, so in_ready does
  // not depend on in_valid.
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_up_rdy;
  logic [STAGES-1:0] w_dn_rdy;
  logic [STAGES-1:0] w_src_v;
  logic [W-1:0]      w_src_d [STAGES];
  logic [W-1:0]      w_d     [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    if (i == 0) begin : g_head
      assign w_src_v[i] = in_valid;
      assign w_src_d[i] = w_perm;
    end else begin : g_body
      assign w_src_v[i] = w_v[i-1];
      assign w_src_d[i] = w_d[i-1];
    end

    if (i == STAGES - 1) begin : g_tail
      assign w_dn_rdy[i] = out_ready;
    end else begin : g_mid
      assign w_dn_rdy[i] = w_up_rdy[i+1];
    end

    des_perm_slice #(
      .W (W)
    ) u_slice (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (w_src_v[i]),
      .i_data     (w_src_d[i]),
      .i_dn_ready (w_dn_rdy[i]),
      .o_up_ready (w_up_rdy[i]),
      .o_valid    (w_v[i]),
      .o_data     (w_d[i])
    );
  end

  assign in_ready  = w_up_rdy[0];
  assign out_valid = w_v[STAGES-1];
  assign out_data  = w_d[STAGES-1];

  // Occupancy is the popcount of the slice valid flags. It follows each
  // clock edge directly, with no separate counter to drift.
  logic [c_occ_w-1:0] w_occ;
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ = w_occ + c_occ_w'(w_v[i]);
    end
  end
  assign occupancy = w_occ;

endmodule
`default_nettype wire
